// File: rtl/dvsd_cnt_pkg.sv
// dvsd_cnt_pkg: mode encodings and FSM state type shared by the up/down counter.
package dvsd_cnt_pkg;
  localparam logic [1:0] CNT_MODE_WRAP    = 2'b00;
  localparam logic [1:0] CNT_MODE_SAT     = 2'b01;
  localparam logic [1:0] CNT_MODE_ONESHOT = 2'b10;
  typedef enum logic {RUN, DONE} cnt_state_e;
endpackage

// File: rtl/dvsd_cnt_step.sv
// dvsd_cnt_step: combinational next-count, terminal and end-of-range event calculator.
module dvsd_cnt_step import dvsd_cnt_pkg::*; #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1
) (
  input  logic [WIDTH-1:0] out,
  input  logic             updown,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] nxt,
  output logic             at_terminal,
  output logic             evt
);
  logic hold;
  always_comb begin
    at_terminal = updown ? (out == MAX_VAL) : (out == '0);
    evt = at_terminal;
    hold = (mode == CNT_MODE_SAT) || (mode == CNT_MODE_ONESHOT);
    // reserved mode 11 falls through to wrap behaviour
    nxt = !at_terminal ? (updown ? out + 1'b1 : out - 1'b1) :
          hold ? out : (updown ? '0 : MAX_VAL);
  end
endmodule

// File: rtl/dvsd_param_updown_counter.sv
// dvsd_param_updown_counter: parametrised up/down counter with load, wrap/saturate/one-shot modes.
// Optional sticky end-of-range flag built when DVSD_CNT_STICKY_OVF_EN is defined.
module dvsd_param_updown_counter import dvsd_cnt_pkg::*; #(
  parameter int unsigned WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX_VAL = '1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             updown,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             done,
  input  logic             ovf_clr,
  output logic             ovf_sticky
);
  cnt_state_e state;
  logic [WIDTH-1:0] nxt, load_clamp;
  logic evt, wrap_d;
  dvsd_cnt_step #(.WIDTH(WIDTH), .MAX_VAL(MAX_VAL)) u_step (
    .out(out), .updown(updown), .mode(mode),
    .nxt(nxt), .at_terminal(tc), .evt(evt)
  );
  assign load_clamp = (load_val > MAX_VAL) ? MAX_VAL : load_val;
  assign wrap_d = !load && (state == RUN) && en && evt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      out <= RST_VAL;
      wrap <= 1'b0;
      done <= 1'b0;
      state <= RUN;
    end else if (load) begin
      out <= load_clamp;
      wrap <= 1'b0;
      done <= 1'b0;
      state <= RUN;
    end else if (state == DONE) begin
      wrap <= 1'b0;
      if (mode != CNT_MODE_ONESHOT) begin
        state <= RUN;
        done <= 1'b0;
      end
    end else begin
      wrap <= wrap_d;
      if (en) out <= nxt;
      if (wrap_d && mode == CNT_MODE_ONESHOT) begin
        state <= DONE;
        done <= 1'b1;
      end
    end
`ifdef DVSD_CNT_STICKY_OVF_EN
  // a new event on the same edge as ovf_clr keeps the flag set
  always_ff @(posedge clk or negedge reset)
    if (!reset) ovf_sticky <= 1'b0;
    else ovf_sticky <= wrap_d | (ovf_sticky & ~ovf_clr);
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign ovf_sticky = 1'b0;
`endif
endmodule
